// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree feeding a multi-pass accumulator and a
// round-half-to-even / saturate output stage.
module adder_tree_acc #(
  parameter int unsigned BITSIZE    = 14,
  parameter int unsigned NUM_INPUTS = 27,
  parameter int unsigned SHIFT      = 7,
  parameter int unsigned OUT_BITS   = 14,
  parameter int unsigned ACC_GUARD  = 4,
  localparam int unsigned LVL = $clog2(NUM_INPUTS),
  localparam int unsigned TW  = BITSIZE + LVL,
  localparam int unsigned AW  = TW + ACC_GUARD
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*BITSIZE-1:0]    input_numbers,
  input  logic                             in_valid,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic                             clear,
  output logic signed [AW-1:0]             sum_raw,
  output logic signed [OUT_BITS-1:0]       sum_output,
  output logic                             data_valid,
  output logic                             sat_flag
);

  // Number of terms held at tree level n (level 0 is the registered operands).
  function automatic int unsigned lvl_cnt(input int unsigned n);
    int unsigned c;
    c = NUM_INPUTS;
    for (int unsigned k = 0; k < n; k++) c = (c + 1) / 2;
    return c;
  endfunction

  // Flat index of the first term of level n.
  function automatic int unsigned lvl_off(input int unsigned n);
    int unsigned o;
    o = 0;
    for (int unsigned k = 0; k < n; k++) o = o + lvl_cnt(k);
    return o;
  endfunction

  localparam int unsigned TOTAL = lvl_off(LVL + 1);
  localparam logic signed [AW-1:0] OMAX = AW'((64'd1 << (OUT_BITS - 1)) - 64'd1);
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  logic signed [TW-1:0] tree_q [TOTAL];
  logic [LVL:0]         vld_q;
  logic [LVL:0]         fst_q;
  logic [LVL:0]         lst_q;

  for (genvar n = 0; n <= LVL; n++) begin : g_lvl
    localparam int unsigned CNT = lvl_cnt(n);
    localparam int unsigned OFF = lvl_off(n);
    for (genvar i = 0; i < CNT; i++) begin : g_node
      logic signed [TW-1:0] d;
      if (n == 0) begin : g_ext
        assign d = {{LVL{input_numbers[i*BITSIZE+BITSIZE-1]}}, input_numbers[i*BITSIZE +: BITSIZE]};
      end else begin : g_sum
        localparam int unsigned PCNT = lvl_cnt(n - 1);
        localparam int unsigned POFF = lvl_off(n - 1);
        // Odd trailing term at a level passes straight through.
        if (2*i + 1 < PCNT) begin : g_pair
          assign d = tree_q[POFF + 2*i] + tree_q[POFF + 2*i + 1];
        end else begin : g_pass
          assign d = tree_q[POFF + 2*i];
        end
      end
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) tree_q[OFF + i] <= '0;
        else      tree_q[OFF + i] <= d;
      end
    end
  end

  // Beat control travels with the data; clear kills every in-flight beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else begin
      vld_q <= clear ? '0 : {vld_q[LVL-1:0], in_valid};
      fst_q <= {fst_q[LVL-1:0], in_first};
      lst_q <= {lst_q[LVL-1:0], in_last};
    end
  end

  logic signed [TW-1:0] tree_sum;
  logic signed [AW-1:0] tree_ext;
  logic signed [AW-1:0] acc_q;
  logic                 acc_done_q;

  assign tree_sum = tree_q[TOTAL-1];
  assign tree_ext = {{ACC_GUARD{tree_sum[TW-1]}}, tree_sum};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      acc_done_q <= 1'b0;
    end else if (clear) begin
      acc_q      <= '0;
      acc_done_q <= 1'b0;
    end else begin
      acc_done_q <= vld_q[LVL] & lst_q[LVL];
      if (vld_q[LVL]) acc_q <= fst_q[LVL] ? tree_ext : acc_q + tree_ext;
    end
  end

  logic                 inc_c;
  logic signed [AW-1:0] shr_c;
  logic signed [AW-1:0] rnd_c;
  logic signed [OUT_BITS-1:0] out_c;
  logic                 sat_c;

  // Round half to even: bump when guard is set and sticky or LSB is set.
  always_comb begin
    inc_c = acc_q[SHIFT-1] & ((|acc_q[SHIFT-2:0]) | acc_q[SHIFT]);
    shr_c = acc_q >>> SHIFT;
    rnd_c = shr_c + AW'(inc_c);
    out_c = rnd_c[OUT_BITS-1:0];
    sat_c = 1'b0;
    if (rnd_c > OMAX) begin
      out_c = OMAX[OUT_BITS-1:0];
      sat_c = 1'b1;
    end else if (rnd_c < OMIN) begin
      out_c = OMIN[OUT_BITS-1:0];
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_raw    <= '0;
      sum_output <= '0;
      sat_flag   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= acc_done_q & ~clear;
      if (acc_done_q && !clear) begin
        sum_raw    <= acc_q;
        sum_output <= out_c;
        sat_flag   <= sat_c;
      end
    end
  end

endmodule
